iicc_tx_sched: RTL and testbench

- Transmit-lane scheduler for the 16-bit 8b10b inter-chassis link.
- Shares the GT TX data/charisk lane between three sources:
  - 8-beat timestamp sync bursts from the link-timing state machine;
  - a user data stream (valid/ready);
  - K28.5 comma idles.
- Guarantees periodic comma insertion for receiver byte alignment and honours far-end alignment requests.
- Sits directly in front of the igticc txdata/txcharisk inputs, in the txusrclk domain.

---
 rtl/iicc_tx_sched_if.sv | 25 ++
 rtl/iicc_tx_sched.sv | 138 +++++++++++++
 tb/tb_iicc_tx_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iicc_tx_sched_if.sv
// Lane-side bundle for iicc_tx_sched: sync burst handshake, user data stream
// and the registered GT txdata/txcharisk pair.
interface iicc_tx_sched_if;
   logic        sync_req;
   logic [4:0]  sync_action;
   logic [63:0] sync_word;
   logic        sync_ack;
   logic        sync_done;
   logic        sync_abort;
   logic [15:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic [15:0] txdata;
   logic [1:0]  txcharisk;

   modport master (
      output sync_req, sync_action, sync_word, data_in, data_valid,
      input  sync_ack, sync_done, sync_abort, data_ready, txdata, txcharisk
   );

   modport slave (
      input  sync_req, sync_action, sync_word, data_in, data_valid,
      output sync_ack, sync_done, sync_abort, data_ready, txdata, txcharisk
   );
endinterface

// File: rtl/iicc_tx_sched.sv
// TX lane scheduler: muxes 8-beat sync bursts, user data and K28.5 commas onto
// the 16-bit GT lane. Define IICC_TX_STATS_EN to build the sync_cnt/data_cnt counters.
module iicc_tx_sched #(
   parameter int unsigned COMMA_PERIOD = 64,
   parameter logic [15:0] COMMA_CHAR   = 16'h00bc
) (
   input  logic           txclk,
   input  logic           sreset_n,
   input  logic           link_up,
   input  logic           align_req,
   iicc_tx_sched_if.slave lane,
   output logic [15:0]    sync_cnt,
   output logic [31:0]    data_cnt
);
   typedef enum logic {IDLE, SYNC} state_t;

   localparam logic [11:0] DUE_LEVEL = 12'(COMMA_PERIOD - 2);

   state_t      state;
   logic [2:0]  bidx;
   logic [4:0]  act_q;
   logic [63:0] word_q;
   logic [11:0] comma_cnt;
   logic [15:0] txdata_q;
   logic [1:0]  txk_q;
   logic        ack_q;
   logic        done_q;
   logic        abort_q;
   logic        comma_due;
   logic        comma_grant;
   logic [7:0]  beat_byte;

   assign comma_due = comma_cnt >= DUE_LEVEL;

   assign lane.data_ready = (state == IDLE) && link_up && !align_req &&
                            !comma_due && !lane.sync_req;

   // Beat k carries byte k counted from the MSB: shift right by (7-k)*8.
   assign beat_byte = 8'(word_q >> {~bidx, 3'b000});

   // A burst in flight is only broken by link loss; align/comma wait for IDLE.
   always_comb begin
      comma_grant = 1'b0;
      if (!link_up) begin
         comma_grant = 1'b1;
      end else if (state == IDLE) begin
         comma_grant = align_req || comma_due ||
                       (!lane.sync_req && !lane.data_valid);
      end
   end

   always_ff @(posedge txclk or negedge sreset_n) begin
      if (!sreset_n) begin
         state    <= IDLE;
         bidx     <= '0;
         act_q    <= '0;
         word_q   <= '0;
         txdata_q <= COMMA_CHAR;
         txk_q    <= 2'b01;
         ack_q    <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         if (comma_grant) begin
            txdata_q <= COMMA_CHAR;
            txk_q    <= 2'b01;
            if (state == SYNC) begin
               abort_q <= 1'b1;
               state   <= IDLE;
            end
         end else if (state == SYNC) begin
            txdata_q <= {act_q, bidx, beat_byte};
            txk_q    <= 2'b00;
            bidx     <= bidx + 3'd1;
            if (bidx == 3'd7) begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
         end else if (lane.sync_req) begin
            act_q    <= lane.sync_action;
            word_q   <= lane.sync_word;
            txdata_q <= {lane.sync_action, 3'd0, lane.sync_word[63:56]};
            txk_q    <= 2'b00;
            ack_q    <= 1'b1;
            bidx     <= 3'd1;
            state    <= SYNC;
         end else begin
            txdata_q <= lane.data_in;
            txk_q    <= 2'b00;
         end
      end
   end

   always_ff @(posedge txclk or negedge sreset_n) begin
      if (!sreset_n) begin
         comma_cnt <= '0;
      end else if (comma_grant) begin
         comma_cnt <= '0;
      end else if (comma_cnt != '1) begin
         comma_cnt <= comma_cnt + 12'd1;
      end
   end

   assign lane.txdata     = txdata_q;
   assign lane.txcharisk  = txk_q;
   assign lane.sync_ack   = ack_q;
   assign lane.sync_done  = done_q;
   assign lane.sync_abort = abort_q;

`ifdef IICC_TX_STATS_EN
   logic        burst_end;
   logic        data_fire;
   logic [15:0] sync_cnt_q;
   logic [31:0] data_cnt_q;

   assign burst_end = (state == SYNC) && link_up && (bidx == 3'd7);
   assign data_fire = lane.data_ready && lane.data_valid;

   always_ff @(posedge txclk or negedge sreset_n) begin
      if (!sreset_n) begin
         sync_cnt_q <= '0;
         data_cnt_q <= '0;
      end else begin
         if (burst_end) sync_cnt_q <= sync_cnt_q + 16'd1;
         if (data_fire) data_cnt_q <= data_cnt_q + 32'd1;
      end
   end

   assign sync_cnt = sync_cnt_q;
   assign data_cnt = data_cnt_q;
`else
   assign sync_cnt = '0;
   assign data_cnt = '0;
`endif
endmodule

// File: tb/tb_iicc_tx_sched.sv
// Directed bench for iicc_tx_sched: lane words are checked against a queue of
// expected beats/data pushed when the stimulus is driven.
module tb_iicc_tx_sched;
   localparam int unsigned P     = 64;
   localparam logic [15:0] COMMA = 16'h00bc;
`ifdef IICC_TX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        txclk     = 1'b0;
   logic        sreset_n  = 1'b0;
   logic        link_up   = 1'b0;
   logic        align_req = 1'b0;
   logic [15:0] sync_cnt;
   logic [31:0] data_cnt;

   iicc_tx_sched_if lane();

   iicc_tx_sched #(.COMMA_PERIOD(P), .COMMA_CHAR(COMMA)) dut (
      .txclk    (txclk),
      .sreset_n (sreset_n),
      .link_up  (link_up),
      .align_req(align_req),
      .lane     (lane),
      .sync_cnt (sync_cnt),
      .data_cnt (data_cnt)
   );

   always #5 txclk = ~txclk;

   int          n_checks   = 0;
   int          n_fail     = 0;
   logic [17:0] exp_q[$];
   int          cyc        = 0;
   int          last_comma = 0;
   int          last_gap   = 0;
   int          n_commas   = 0;
   int          n_data_out = 0;
   int          n_acc      = 0;
   int          exp_sync   = 0;
   bit          mon_en     = 1'b0;
   logic [15:0] tp_beats [8] = '{16'h0801, 16'h0923, 16'h0a45, 16'h0b67,
                                 16'h0c89, 16'h0dab, 16'h0ecd, 16'h0fef};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] beat(input logic [4:0] a, input int k, input logic [63:0] w);
      logic [7:0] b;
      b = w[63-8*k -: 8];
      return {a, 3'(k), b};
   endfunction

   // Lane monitor: commas must be the K28.5 word, everything else pops the scoreboard.
   always @(negedge txclk) begin
      if (mon_en) begin
         cyc++;
         if (lane.txcharisk == 2'b01) begin
            chk("comma_word", {48'd0, lane.txdata}, {48'd0, COMMA});
            last_gap   = cyc - last_comma;
            last_comma = cyc;
            n_commas++;
         end else if (exp_q.size() == 0) begin
            chk("unexpected_word", {46'd0, lane.txcharisk, lane.txdata}, 64'h3ffff);
         end else begin
            chk("lane_word", {46'd0, lane.txcharisk, lane.txdata}, {46'd0, exp_q.pop_front()});
            n_data_out++;
         end
      end
   end

   task automatic tick();
      bit acc;
      #1;
      acc = lane.data_valid && lane.data_ready;
      if (acc) begin
         exp_q.push_back({2'b00, lane.data_in});
         n_acc++;
      end
      @(posedge txclk);
      @(negedge txclk);
      #1;
      if (acc) lane.data_in = 16'($urandom);
   endtask

   task automatic start_sync(input logic [4:0] a, input logic [63:0] w);
      lane.sync_action = a;
      lane.sync_word   = w;
      lane.sync_req    = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back({2'b00, beat(a, k, w)});
   endtask

   task automatic wait_ack(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!lane.sync_ack && n < 20);
      chk({tag, "_ack"}, {63'd0, lane.sync_ack}, 64'd1);
      lane.sync_req = 1'b0;
   endtask

   task automatic chk_ready(input string tag, input logic exp);
      #1;
      chk(tag, {63'd0, lane.data_ready}, {63'd0, exp});
   endtask

   task automatic wait_comma(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (lane.txcharisk != 2'b01 && n < 80);
      chk({tag, "_comma_seen"}, {62'd0, lane.txcharisk}, 64'd1);
   endtask

   initial begin
      int c0;
      int d0;
      bit r;
      lane.sync_req    = 1'b0;
      lane.sync_action = '0;
      lane.sync_word   = '0;
      lane.data_in     = 16'h1234;
      lane.data_valid  = 1'b0;

      // Reset state
      repeat (2) @(negedge txclk);
      chk("rst_txdata", {48'd0, lane.txdata}, {48'd0, COMMA});
      chk("rst_txk", {62'd0, lane.txcharisk}, 64'd1);
      chk("rst_ack", {63'd0, lane.sync_ack}, 64'd0);
      chk("rst_done", {63'd0, lane.sync_done}, 64'd0);
      chk("rst_abort", {63'd0, lane.sync_abort}, 64'd0);
      chk("rst_sync_cnt", {48'd0, sync_cnt}, 64'd0);
      chk("rst_data_cnt", {32'd0, data_cnt}, 64'd0);
      #1;
      sreset_n = 1'b1;
      link_up  = 1'b1;
      mon_en   = 1'b1;

      // Idle link: commas only, always ready
      for (int i = 0; i < 10; i++) begin
         chk_ready("idle_ready", 1'b1);
         tick();
         chk("idle_txk", {62'd0, lane.txcharisk}, 64'd1);
      end

      // Test-plan sync burst
      start_sync(5'h01, 64'h0123456789abcdef);
      wait_ack("tp");
      chk("tp_beat0", {48'd0, lane.txdata}, {48'd0, tp_beats[0]});
      chk("tp_done0", {63'd0, lane.sync_done}, 64'd0);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("tp_beat", {48'd0, lane.txdata}, {48'd0, tp_beats[k]});
         chk("tp_done", {63'd0, lane.sync_done}, {63'd0, k == 7});
      end
      exp_sync++;
      chk("tp_sync_cnt", {48'd0, sync_cnt}, STATS ? 64'(exp_sync) : 64'd0);

      // Continuous data: ready low exactly on comma grants, one comma per period
      lane.data_valid = 1'b1;
      lane.data_in    = 16'($urandom);
      wait_comma("stream");
      c0 = n_commas;
      d0 = n_data_out;
      for (int i = 0; i < 128; i++) begin
         #1;
         r = lane.data_ready;
         tick();
         chk("stream_ready_vs_comma", {62'd0, lane.txcharisk}, r ? 64'd0 : 64'd1);
      end
      chk("stream_commas", 64'(n_commas - c0), 64'd2);
      chk("stream_words", 64'(n_data_out - d0), 64'd126);
      chk("stream_gap", {63'd0, (last_gap == int'(P) - 1) || (last_gap == int'(P))}, 64'd1);
      chk("stream_data_cnt", {32'd0, data_cnt}, STATS ? 64'(n_acc) : 64'd0);

      // Burst starting with the comma counter at P-4 defers the comma past beat 7
      wait_comma("defer");
      for (int i = 0; i < int'(P) - 4; i++) begin
         tick();
         chk("defer_pre_data", {62'd0, lane.txcharisk}, 64'd0);
      end
      start_sync(5'h1a, 64'hfedcba9876543210);
      chk_ready("both_req_ready", 1'b0);
      wait_ack("defer");
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("defer_beat_txk", {62'd0, lane.txcharisk}, 64'd0);
      end
      chk("defer_done", {63'd0, lane.sync_done}, 64'd1);
      exp_sync++;
      tick();
      chk("defer_comma_after", {62'd0, lane.txcharisk}, 64'd1);
      chk("defer_gap", {63'd0, last_gap <= int'(P) + 7}, 64'd1);
      chk("defer_sync_cnt", {48'd0, sync_cnt}, STATS ? 64'(exp_sync) : 64'd0);

      // link_up drop after beat 3 aborts the burst
      lane.data_valid = 1'b0;
      tick();
      start_sync(5'h03, 64'h1122334455667788);
      wait_ack("abort");
      repeat (3) tick();
      chk("abort_beat3", {48'd0, lane.txdata}, {48'd0, 16'h1b44});
      link_up = 1'b0;
      tick();
      chk("abort_txk", {62'd0, lane.txcharisk}, 64'd1);
      chk("abort_pulse", {63'd0, lane.sync_abort}, 64'd1);
      chk("abort_no_done", {63'd0, lane.sync_done}, 64'd0);
      chk("abort_left", 64'(exp_q.size()), 64'd4);
      exp_q.delete();
      lane.data_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk_ready("down_ready", 1'b0);
         tick();
         chk("down_txk", {62'd0, lane.txcharisk}, 64'd1);
         chk("down_abort", {63'd0, lane.sync_abort}, 64'd0);
         chk("down_done", {63'd0, lane.sync_done}, 64'd0);
      end
      chk("abort_sync_cnt", {48'd0, sync_cnt}, STATS ? 64'(exp_sync) : 64'd0);

      // align_req for 20 cycles holds off data
      link_up   = 1'b1;
      align_req = 1'b1;
      c0 = n_commas;
      for (int i = 0; i < 20; i++) begin
         chk_ready("align_ready", 1'b0);
         tick();
      end
      chk("align_commas", 64'(n_commas - c0), 64'd20);
      align_req = 1'b0;
      chk_ready("align_release_ready", 1'b1);
      tick();
      chk("align_resume_txk", {62'd0, lane.txcharisk}, 64'd0);

      lane.data_valid = 1'b0;
      repeat (3) tick();
      chk("final_data_cnt", {32'd0, data_cnt}, STATS ? 64'(n_acc) : 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
